// File: rtl/mem_data_buffer.sv
// Memory data register stage between the CPU datapath and the data cache.
// Store side: lane-aligns store data, builds byte enables and queues entries
// in a DEPTH-deep FIFO drained to the cache. Load side: extracts and extends
// the addressed bytes of a cache read line into a held output register.
//
// Handshakes: every channel uses strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both 1. A valid source holds its
// payload stable until the transfer. st_ready and cache_wr_valid come only
// from registered state, so they have no combinational path from the other
// side. cache_rd_ready depends on ld_out_ack, so the CPU can free the output
// register and refill it on the same edge.
module mem_data_buffer #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [N-1:0]                 st_data,
  input  logic [1:0]                   st_size,
  input  logic [$clog2(N/8)-1:0]       st_offset,
  output logic                         cache_wr_valid,
  input  logic                         cache_wr_ready,
  output logic [N-1:0]                 cache_wr_data,
  output logic [N/8-1:0]               cache_wr_be,
  output logic [$clog2(DEPTH):0]       st_count,
  input  logic                         cache_rd_valid,
  output logic                         cache_rd_ready,
  input  logic [N-1:0]                 cache_rd_data,
  input  logic [1:0]                   ld_size,
  input  logic                         ld_signed,
  input  logic [$clog2(N/8)-1:0]       ld_offset,
  output logic [N-1:0]                 ld_out,
  output logic                         ld_out_valid,
  input  logic                         ld_out_ack
);

  localparam int NB = N / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]  fifo_data [DEPTH];
  logic [NB-1:0] fifo_be   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [N-1:0]  st_al_data;
  logic [NB-1:0] st_al_be;
  logic [N-1:0]  ld_ext;
  logic          capture;

  assign st_ready       = (count != CW'(DEPTH));
  assign cache_wr_valid = (count != '0);
  assign push           = st_valid && st_ready;
  assign pop            = cache_wr_valid && cache_wr_ready;
  assign st_count       = count;
  assign cache_wr_data  = fifo_data[rd_ptr];
  assign cache_wr_be    = fifo_be[rd_ptr];

  assign cache_rd_ready = !ld_out_valid || ld_out_ack;
  assign capture        = cache_rd_valid && cache_rd_ready;

  // Store alignment: replicate the low access bytes into every lane and
  // enable only the lanes covered by the size-aligned offset.
  always_comb begin : st_align
    int nb;
    int off;
    nb  = 1 << st_size;
    if (nb > NB) nb = NB;
    off = int'(st_offset) & ~(nb - 1);
    if (nb == NB) off = 0;
    st_al_data = '0;
    st_al_be   = '0;
    for (int i = 0; i < NB; i++) begin
      st_al_data[8*i +: 8] = st_data[8*(i % nb) +: 8];
      st_al_be[i]          = (i >= off) && (i < off + nb);
    end
  end

  // Load extraction: right-justify the addressed bytes, then fill the upper
  // bits with zero or with the top extracted bit.
  always_comb begin : ld_extract
    int   nb;
    int   off;
    int   idx;
    logic sgn;
    nb  = 1 << ld_size;
    if (nb > NB) nb = NB;
    off = int'(ld_offset) & ~(nb - 1);
    if (nb == NB) off = 0;
    idx    = 0;
    ld_ext = '0;
    for (int b = 0; b < N; b++) begin
      idx = 8*off + b;
      if ((b < 8*nb) && (idx < N)) ld_ext[b] = cache_rd_data[idx];
    end
    sgn = ld_ext[8*nb-1] & ld_signed;
    for (int b = 0; b < N; b++) begin
      if (b >= 8*nb) ld_ext[b] = sgn;
    end
  end

  // FIFO storage: the entry is written at the tail on every accepted store.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= st_al_data;
      fifo_be[wr_ptr]   <= st_al_be;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Load output register: capture wins over ack; a bare ack only drops valid.
  always_ff @(posedge clk) begin
    if (clr) begin
      ld_out       <= '0;
      ld_out_valid <= 1'b0;
    end else if (capture) begin
      ld_out       <= ld_ext;
      ld_out_valid <= 1'b1;
    end else if (ld_out_ack) begin
      ld_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_data_buffer.sv
// Bench for mem_data_buffer (N=32, DEPTH=4). Inputs change 1 ns after each
// rising edge; a negedge monitor scores cache writes and load results
// against queues of expected values built from independent models.
module tb_mem_data_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic [1:0]  st_offset;
  logic        cache_wr_valid;
  logic        cache_wr_ready;
  logic [31:0] cache_wr_data;
  logic [3:0]  cache_wr_be;
  logic [2:0]  st_count;
  logic        cache_rd_valid;
  logic        cache_rd_ready;
  logic [31:0] cache_rd_data;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  ld_offset;
  logic [31:0] ld_out;
  logic        ld_out_valid;
  logic        ld_out_ack;

  mem_data_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .st_size(st_size), .st_offset(st_offset),
    .cache_wr_valid(cache_wr_valid), .cache_wr_ready(cache_wr_ready),
    .cache_wr_data(cache_wr_data), .cache_wr_be(cache_wr_be),
    .st_count(st_count),
    .cache_rd_valid(cache_rd_valid), .cache_rd_ready(cache_rd_ready),
    .cache_rd_data(cache_rd_data), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_offset(ld_offset), .ld_out(ld_out), .ld_out_valid(ld_out_valid),
    .ld_out_ack(ld_out_ack)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- models ----------------
  logic [35:0] exp_q[$];   // {be, data} of expected cache writes
  logic [31:0] ld_q[$];    // expected load results

  function automatic logic [35:0] st_model(input logic [31:0] d,
                                           input logic [1:0] sz,
                                           input logic [1:0] off);
    logic [31:0] wd;
    logic [3:0]  be;
    case (sz)
      2'd0: begin wd = {4{d[7:0]}};  be = 4'b0001 << off; end
      2'd1: begin wd = {2{d[15:0]}}; be = 4'b0011 << {off[1], 1'b0}; end
      default: begin wd = d; be = 4'b1111; end
    endcase
    return {be, wd};
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] d,
                                           input logic [1:0] sz,
                                           input logic [1:0] off,
                                           input logic sgn);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin
        sh = d >> (8 * off);
        b  = sh[7:0];
        return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'd1: begin
        sh = d >> (16 * off[1]);
        h  = sh[15:0];
        return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return d;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    logic [31:0] l;
    if (!clr) begin
      if (cache_wr_valid && cache_wr_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_pop_unexpected: got %h/%b, expected no entry", cache_wr_data, cache_wr_be);
        end else begin
          e = exp_q.pop_front();
          if ({cache_wr_be, cache_wr_data} !== e) begin
            n_err++;
            $display("FAIL wr_entry: got be=%b data=%h, expected be=%b data=%h",
                     cache_wr_be, cache_wr_data, e[35:32], e[31:0]);
          end
        end
      end
      if (st_valid && st_ready) exp_q.push_back(st_model(st_data, st_size, st_offset));
      if (ld_out_valid && ld_out_ack) begin
        n_vec++;
        if (ld_q.size() == 0) begin
          n_err++;
          $display("FAIL ld_ack_unexpected: got %h, expected no result", ld_out);
        end else begin
          l = ld_q.pop_front();
          if (ld_out !== l) begin
            n_err++;
            $display("FAIL ld_result: got %h, expected %h", ld_out, l);
          end
        end
      end
      if (cache_rd_valid && cache_rd_ready)
        ld_q.push_back(ld_model(cache_rd_data, ld_size, ld_offset, ld_signed));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_valid = 0; st_data = '0; st_size = 0; st_offset = 0;
    cache_wr_ready = 0; cache_rd_valid = 0; cache_rd_data = '0;
    ld_size = 0; ld_signed = 0; ld_offset = 0; ld_out_ack = 0;
  endtask

  task automatic drive_store(input logic [31:0] d, input logic [1:0] sz, input logic [1:0] off);
    st_valid = 1; st_data = d; st_size = sz; st_offset = off;
  endtask

  task automatic drain_all();
    st_valid = 0; cache_wr_ready = 1;
    for (int i = 0; i < 20 && st_count != 0; i++) tick();
    cache_wr_ready = 0;
    #1;
    n_vec++;
    if (st_count !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: st_count=%0d queue=%0d, expected 0/0", st_count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    clr = 1; st_valid = 1; st_data = 32'h1234_5678; cache_rd_valid = 1;
    tick();
    n_vec++;
    if (st_count !== 3'd0 || cache_wr_valid !== 1'b0 || ld_out_valid !== 1'b0 || ld_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_first_edge: cnt=%0d wv=%b lv=%b lo=%h, expected 0 0 0 0",
               st_count, cache_wr_valid, ld_out_valid, ld_out);
    end
    tick();
    n_vec++;
    if (st_count !== 3'd0 || cache_wr_valid !== 1'b0 || ld_out_valid !== 1'b0 || ld_out !== 32'h0 || st_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold: cnt=%0d wv=%b lv=%b lo=%h rdy=%b, expected 0 0 0 0 1",
               st_count, cache_wr_valid, ld_out_valid, ld_out, st_ready);
    end
    idle_inputs();
    clr = 0;
    tick();
  endtask

  task automatic test_store_align();
    logic [31:0] d_tab  [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'hDEAD_BEEF};
    logic [1:0]  sz_tab [3] = '{2'd0, 2'd1, 2'd2};
    logic [1:0]  off_tab[3] = '{2'd2, 2'd3, 2'd3};
    logic [31:0] ed_tab [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'hDEAD_BEEF};
    logic [3:0]  eb_tab [3] = '{4'b0100, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      drive_store(d_tab[i], sz_tab[i], off_tab[i]);
      tick();
      st_valid = 0;
      n_vec++;
      if (cache_wr_valid !== 1'b1 || cache_wr_data !== ed_tab[i] || cache_wr_be !== eb_tab[i]) begin
        n_err++;
        $display("FAIL store_align[%0d]: v=%b data=%h be=%b, expected 1 %h %b",
                 i, cache_wr_valid, cache_wr_data, cache_wr_be, ed_tab[i], eb_tab[i]);
      end
      cache_wr_ready = 1;
      tick();
      cache_wr_ready = 0;
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive_store($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      tick();
    end
    drive_store(32'hFFFF_0000, 2'd2, 2'd0);
    #1;
    n_vec++;
    if (st_count !== 3'd4 || st_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: cnt=%0d rdy=%b, expected 4 0", st_count, st_ready);
    end
    tick(); tick();
    n_vec++;
    if (st_count !== 3'd4 || exp_q.size() != 4) begin
      n_err++;
      $display("FAIL fill_holdoff: cnt=%0d queue=%0d, expected 4 4", st_count, exp_q.size());
    end
    st_valid = 0;
    cache_wr_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_vec++;
      if (cache_wr_valid !== 1'b1 || st_count !== 3'(DEPTH - i)) begin
        n_err++;
        $display("FAIL drain_step[%0d]: v=%b cnt=%0d, expected 1 %0d", i, cache_wr_valid, st_count, DEPTH - i);
      end
      tick();
    end
    cache_wr_ready = 0;
    n_vec++;
    if (cache_wr_valid !== 1'b0 || st_count !== 3'd0) begin
      n_err++;
      $display("FAIL drain_end: v=%b cnt=%0d, expected 0 0", cache_wr_valid, st_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive_store($urandom, 2'd2, 2'd0);
      tick();
    end
    cache_wr_ready = 1;
    for (int i = 0; i < 5; i++) begin
      drive_store($urandom, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
      tick();
      n_vec++;
      if (st_count !== 3'd2) begin
        n_err++;
        $display("FAIL push_pop_count[%0d]: cnt=%0d, expected 2", i, st_count);
      end
    end
    drain_all();
  endtask

  task automatic test_empty_latency();
    drive_store(32'h0000_5A5A, 2'd1, 2'd0);
    #1;
    n_vec++;
    if (cache_wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL no_bypass: v=%b, expected 0", cache_wr_valid);
    end
    tick();
    st_valid = 0;
    n_vec++;
    if (cache_wr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL empty_latency: v=%b, expected 1", cache_wr_valid);
    end
    drain_all();
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz_tab [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic [1:0]  off_tab[4] = '{2'd1, 2'd3, 2'd2, 2'd1};
    logic        sg_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex_tab [4] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80F1, 32'h80F1_7F22};
    for (int i = 0; i < 4; i++) begin
      cache_rd_valid = 1; cache_rd_data = 32'h80F1_7F22;
      ld_size = sz_tab[i]; ld_offset = off_tab[i]; ld_signed = sg_tab[i];
      ld_out_ack = ld_out_valid;
      #1;
      n_vec++;
      if (cache_rd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL ld_ready[%0d]: got %b, expected 1", i, cache_rd_ready);
      end
      tick();
      cache_rd_valid = 0; ld_out_ack = 0;
      n_vec++;
      if (ld_out_valid !== 1'b1 || ld_out !== ex_tab[i]) begin
        n_err++;
        $display("FAIL ld_ext[%0d]: v=%b out=%h, expected 1 %h", i, ld_out_valid, ld_out, ex_tab[i]);
      end
    end
    ld_out_ack = 1;
    tick();
    ld_out_ack = 0;
  endtask

  task automatic test_load_backpressure();
    cache_rd_valid = 1; cache_rd_data = 32'h1122_3344; ld_size = 2'd2; ld_offset = 0; ld_signed = 0;
    tick();
    cache_rd_data = 32'hAABB_CCDD; ld_size = 2'd0; ld_offset = 2'd2; ld_signed = 1;
    #1;
    n_vec++;
    if (cache_rd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready: got %b, expected 0", cache_rd_ready);
    end
    tick();
    n_vec++;
    if (ld_out_valid !== 1'b1 || ld_out !== 32'h1122_3344) begin
      n_err++;
      $display("FAIL bp_hold: v=%b out=%h, expected 1 11223344", ld_out_valid, ld_out);
    end
    ld_out_ack = 1;
    #1;
    n_vec++;
    if (cache_rd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ack_ready: got %b, expected 1", cache_rd_ready);
    end
    tick();
    cache_rd_valid = 0;
    n_vec++;
    if (ld_out_valid !== 1'b1 || ld_out !== 32'hFFFF_FFBB) begin
      n_err++;
      $display("FAIL bp_replace: v=%b out=%h, expected 1 ffffffbb", ld_out_valid, ld_out);
    end
    tick();
    n_vec++;
    if (ld_out_valid !== 1'b0 || ld_out !== 32'hFFFF_FFBB) begin
      n_err++;
      $display("FAIL bp_ack_retain: v=%b out=%h, expected 0 ffffffbb", ld_out_valid, ld_out);
    end
    tick();
    ld_out_ack = 0;
    n_vec++;
    if (ld_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_idle_ack: v=%b, expected 0", ld_out_valid);
    end
  endtask

  task automatic test_mid_clr();
    for (int i = 0; i < 2; i++) begin
      drive_store($urandom, 2'd2, 2'd0);
      tick();
    end
    cache_rd_valid = 1; cache_rd_data = 32'hCAFE_F00D; ld_size = 2'd2;
    tick();
    clr = 1;
    tick();
    clr = 0;
    idle_inputs();
    exp_q.delete();
    ld_q.delete();
    n_vec++;
    if (st_count !== 3'd0 || cache_wr_valid !== 1'b0 || ld_out_valid !== 1'b0 || ld_out !== 32'h0) begin
      n_err++;
      $display("FAIL mid_clr: cnt=%0d wv=%b lv=%b lo=%h, expected 0 0 0 0",
               st_count, cache_wr_valid, ld_out_valid, ld_out);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      st_valid       = 1'($urandom_range(0, 1));
      st_data        = $urandom;
      st_size        = 2'($urandom_range(0, 3));
      st_offset      = 2'($urandom_range(0, 3));
      cache_wr_ready = 1'($urandom_range(0, 1));
      cache_rd_valid = 1'($urandom_range(0, 1));
      cache_rd_data  = $urandom;
      ld_size        = 2'($urandom_range(0, 3));
      ld_offset      = 2'($urandom_range(0, 3));
      ld_signed      = 1'($urandom_range(0, 1));
      ld_out_ack     = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    ld_out_ack = 1;
    for (int i = 0; i < 4; i++) tick();
    ld_out_ack = 0;
    drain_all();
    n_vec++;
    if (ld_q.size() != 0 || ld_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_ld_drain: queue=%0d v=%b, expected 0 0", ld_q.size(), ld_out_valid);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_inputs();
    clr = 1;
    test_reset();
    test_store_align();
    test_fill_drain();
    test_back_to_back();
    test_empty_latency();
    test_load_ext();
    test_load_backpressure();
    test_mid_clr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
